// File: rtl/gfau_pkg.sv
// gfau_pkg: GFAU op codes, point-add controller states and micro-op format
package gfau_pkg;
  localparam logic [1:0] GF_ADD  = 2'd0;
  localparam logic [1:0] GF_SUB  = 2'd1;
  localparam logic [1:0] GF_MULT = 2'd2;
  localparam logic [1:0] GF_DIV  = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_WB, S_DONE} state_t;
  typedef struct packed {
    logic [1:0] op;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [2:0] dst;
  } uop_t;
endpackage

// File: rtl/ec_point_add_ctrl_if.sv
// ec_point_add_ctrl_if: GFAU operand and go/done bus between the sequencer (master) and the GFAU (slave)
interface ec_point_add_ctrl_if #(parameter int SIZE = 32);
  logic [SIZE-1:0] gf_in_0;
  logic [SIZE-1:0] gf_in_1;
  logic [SIZE-1:0] gf_prime;
  logic [SIZE-1:0] gf_result;
  logic [1:0]      gf_op;
  logic            gf_go;
  logic            gf_done;
  modport master(output gf_in_0, gf_in_1, gf_prime, gf_op, gf_go, input gf_done, gf_result);
  modport slave(input gf_in_0, gf_in_1, gf_prime, gf_op, gf_go, output gf_done, gf_result);
endinterface

// File: rtl/ec_padd_uop_rom.sv
// ec_padd_uop_rom: nine-entry point-add schedule (r4=lam, r6=x3, r7=y3) with result-write flags
module ec_padd_uop_rom
  import gfau_pkg::*;
(
  input  logic [3:0] pc,
  output uop_t       uop,
  output logic       wr_x3,
  output logic       wr_y3
);
  assign wr_x3 = pc == 4'd5;
  assign wr_y3 = pc == 4'd8;
  always_comb begin
    uop = '0;
    case (pc)
      4'd0: uop = '{GF_SUB,  3'd3, 3'd1, 3'd4};
      4'd1: uop = '{GF_SUB,  3'd2, 3'd0, 3'd5};
      4'd2: uop = '{GF_DIV,  3'd4, 3'd5, 3'd4};
      4'd3: uop = '{GF_MULT, 3'd4, 3'd4, 3'd5};
      4'd4: uop = '{GF_SUB,  3'd5, 3'd0, 3'd5};
      4'd5: uop = '{GF_SUB,  3'd5, 3'd2, 3'd6};
      4'd6: uop = '{GF_SUB,  3'd0, 3'd6, 3'd5};
      4'd7: uop = '{GF_MULT, 3'd4, 3'd5, 3'd5};
      4'd8: uop = '{GF_SUB,  3'd5, 3'd1, 3'd7};
      default: uop = '0;
    endcase
  end
endmodule

// File: rtl/ec_point_add_ctrl.sv
// ec_point_add_ctrl: affine EC point-add sequencer issuing a fixed uop schedule to one shared GFAU
module ec_point_add_ctrl
  import gfau_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [SIZE-1:0] i_x1,
  input  logic [SIZE-1:0] i_y1,
  input  logic [SIZE-1:0] i_x2,
  input  logic [SIZE-1:0] i_y2,
  input  logic [SIZE-1:0] i_prime,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_exc,
  output logic [SIZE-1:0] o_x3,
  output logic [SIZE-1:0] o_y3,
  ec_point_add_ctrl_if.master gf
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t          state, state_n;
  logic [3:0]      pc;
  logic [WW-1:0]   wd;
  logic            exc_q, timeout, wr_x3, wr_y3, go;
  logic [SIZE-1:0] rf [8];
  logic [SIZE-1:0] res_q;
  uop_t            uop;
  ec_padd_uop_rom rom (.pc(pc), .uop(uop), .wr_x3(wr_x3), .wr_y3(wr_y3));
  assign timeout = wd == WW'(TIMEOUT - 1);
  always_comb begin
    state_n = state == S_IDLE  ? (i_start ? S_CHECK : S_IDLE) :
              state == S_CHECK ? (rf[0] == rf[2] ? S_DONE : S_ISSUE) :
              state == S_ISSUE ? S_WAIT :
              state == S_WAIT  ? (gf.gf_done ? S_WB : timeout ? S_DONE : S_WAIT) :
              state == S_WB    ? (pc == 4'd8 ? S_DONE : S_ISSUE) : S_IDLE;
    go = state == S_ISSUE || state == S_WAIT;
    o_busy = state != S_IDLE && state != S_DONE;
    o_done = state == S_DONE;
    o_exc = o_done && exc_q;
    gf.gf_go = go;
    gf.gf_op = go ? uop.op : GF_ADD;
    gf.gf_in_0 = rf[uop.src_a];
    gf.gf_in_1 = rf[uop.src_b];
    gf.gf_prime = i_prime;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      pc <= '0;
      wd <= '0;
      exc_q <= 1'b0;
      o_x3 <= '0;
      o_y3 <= '0;
    end else begin
      state <= state_n;
      wd <= state_n == S_ISSUE ? '0 : state == S_WAIT ? wd + WW'(1) : wd;
      if (state == S_IDLE && i_start) begin
        rf[0] <= i_x1;
        rf[1] <= i_y1;
        rf[2] <= i_x2;
        rf[3] <= i_y2;
      end
      if (state == S_CHECK) begin
        pc <= '0;
        exc_q <= rf[0] == rf[2];
      end
      if (state == S_WAIT) begin
        exc_q <= !gf.gf_done && timeout;
        if (gf.gf_done) res_q <= gf.gf_result;
      end
      if (state == S_WB) begin
        rf[uop.dst] <= res_q;
        pc <= pc + 4'd1;
        if (wr_x3) o_x3 <= res_q;
        if (wr_y3) o_y3 <= res_q;
      end
    end
  end
endmodule

// File: doc/ec_point_add_ctrl.md
# ec_point_add_ctrl

Micro-sequencer that computes an affine elliptic-curve point addition R = P1 + P2 over GF(p) by issuing a fixed nine-operation schedule to one shared GFAU (add/sub/mult/div). It holds the operands and intermediate values in a small register file and drives the GFAU start/done handshake. It also detects the P1.x == P2.x exception and guards against a hung GFAU with a watchdog. It sits between the ECC top-level control and the GFAU instance.

## Interface
- SIZE, 32, field element width (matches GFAU)
- TIMEOUT, 1024, max cycles to wait for GFAU done per operation (≥2)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start request, sampled only in IDLE
- i_x1, i_y1, i_x2, i_y2  in  SIZE each  input points, each < i_prime (caller guarantees, not checked)
- i_prime  in  SIZE  field modulus, held stable while o_busy
- o_busy  out  1  high from the cycle after accepted start until DONE
- o_done  out  1  one-cycle pulse, result/exception valid
- o_exc  out  1  valid with o_done: 1 = x1==x2 or GFAU timeout
- o_x3, o_y3  out  SIZE  result, held until next accepted start
- o_gf_in_0, o_gf_in_1, o_gf_prime  out  SIZE  GFAU operands
- o_gf_op  out  2  GFAU operation select
- o_gf_go  out  1  GFAU start/request (done_from_control side)
- i_gf_done  in  1  GFAU completion (done_to_control)
- i_gf_result  in  SIZE  GFAU result, valid when i_gf_done

## Operation
- Op encoding: 0 add, 1 sub, 2 mult, 3 div.
- Register file, 8 × SIZE: r0=x1, r1=y1, r2=x2, r3=y2, r4..r7 temporaries.
- Schedule, pc 0..8:
  - t0=y2−y1
  - t1=x2−x1
  - lam=t0/t1
  - t2=lam·lam
  - t3=t2−x1
  - x3=t3−x2 (also written to o_x3)
  - t4=x1−x3
  - t5=lam·t4
  - y3=t5−y1 (also written to o_y3)
- Temporaries are reused freely by the uop ROM; its contents fix the allocation.
- FSM states:
  - IDLE: on i_start, latch the inputs into r0..r3 and go to CHECK.
  - CHECK: if x1==x2, set o_exc and go to DONE. Otherwise pc=0 and go to ISSUE.
  - ISSUE: go to WAIT.
  - WAIT: on i_gf_done, go to WB. If the watchdog reaches TIMEOUT first, set o_exc and go to DONE.
  - WB: write i_gf_result to the destination register and increment pc. If pc was 8, go to DONE; otherwise go to ISSUE.
  - DONE: pulse o_done and return to IDLE.
- o_gf_go=1 exactly in ISSUE and WAIT. It is low in WB, so go is low for at least one cycle between operations.
- o_gf_in_0, o_gf_in_1 and o_gf_op are driven from the current uop and are stable throughout ISSUE and WAIT. o_gf_prime = i_prime.
- i_gf_done is ignored outside WAIT.
- i_start while busy is ignored. It is not queued.
- The watchdog counter clears on entry to ISSUE and counts every WAIT cycle.

## Timing
- Reset values (next edge after i_rst=1):
  - state IDLE, pc 0, watchdog 0, register file unchanged
  - o_busy 0, o_done 0, o_exc 0, o_x3 0, o_y3 0, o_gf_go 0
  - o_gf_op 0; o_gf_in_0 and o_gf_in_1 equal the RF contents selected by uop 0
- Reset mid-operation: go drops at the next edge and no write-back occurs. A done arriving later is ignored.
- Start accepted at edge k: o_busy=1 from k+1 (CHECK).
- Per operation with GFAU latency L (go-high cycle to done cycle): L+2 cycles (ISSUE, WAIT×L, WB).
- Total start-to-o_done = 1 (CHECK) + Σ(Li+2) + 1 (DONE).
- Exception path (x1==x2): o_done at start+2, and o_gf_go never rises.
- Timeout: o_exc and o_done assert with o_gf_go low in DONE. o_x3 and o_y3 are not updated.
- o_done and o_exc are single-cycle. o_exc is low whenever o_done is low.
- Simultaneous i_gf_done and the watchdog limit in the same WAIT cycle: done wins.

## Structure
- Package gfau_pkg holds:
  - the op-encoding localparams GF_ADD, GF_SUB, GF_MULT, GF_DIV
  - the FSM state enum
  - the uop struct {op[1:0], srcA[2:0], srcB[2:0], dst[2:0]}
- Sub-module ec_padd_uop_rom: combinational, pc[3:0] in, uop out. Holds the nine-entry schedule and marks pc 5 and pc 8 as result writes.

## Test plan
- p=97, P1=(2,5), P2=(5,3), behavioural GFAU L=3 → o_done after 1+9·5+1=47 cycles, o_exc=0, (o_x3,o_y3)=(15,36), lam internally 64.
- p=97, P1=(1,2), P2=(3,6) → (0,0), o_exc=0. Check that o_gf_go is low for exactly one cycle between all 9 ops.
- P1=(7,1), P2=(7,9) → o_done 2 cycles after start, o_exc=1, zero GFAU requests issued.
- TIMEOUT=16, GFAU model withholds done on op 3 → o_exc=1 and o_done exactly 16 WAIT cycles after that ISSUE, o_gf_go=0, o_x3 and o_y3 unchanged.
- i_rst=1 asserted during WAIT of op 4 → next cycle o_gf_go=0, o_busy=0. A late i_gf_done is ignored, and a fresh start then yields a correct result.
- i_start pulsed during busy, and spurious i_gf_done pulses in WB/IDLE → no effect on the result or the op count.
